// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control FSM: opcodes, state numbers and ALU op codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LD   = 3'b000,
    OP_MV   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_LDPC = 3'b101,
    OP_BR   = 3'b110,
    OP_ILL  = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DECODE = 4'd1,
    ST_LOAD   = 4'd2,
    ST_MOV    = 4'd3,
    ST_LDPC   = 4'd4,
    ST_BRANCH = 4'd5,
    ST_ALU    = 4'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_XOR = 2'b10
  } alu_op_e;

endpackage

// File: rtl/ctrl_step_counter.sv
// Step counter for the multi-cycle ALU sequence; clear wins over enable.
module ctrl_step_counter #(
  parameter int STEPS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count,
  output logic       last
);

  localparam logic [2:0] LAST_IDX = 3'(STEPS - 1);

  always_ff @(posedge clock) begin
    if (!resetn)  count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 3'd1;
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// CPU control FSM: captures an instruction, decodes it and sequences datapath enables.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int ALU_STEPS = 3,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               new_instr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         state,
  output logic [2:0]         alu_step,
  output logic [1:0]         alu_op,
  output logic               mem_req,
  output logic               ld_en,
  output logic               mv_en,
  output logic               alu_a_en,
  output logic               alu_g_en,
  output logic               alu_wb_en,
  output logic               pc_ld_en,
  output logic               br_en,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam logic [2:0] G_STEP  = 3'(ALU_STEPS - 2);
  localparam logic [2:0] WB_STEP = 3'(ALU_STEPS - 1);

  state_e     state_q;
  logic [2:0] step;
  logic [2:0] step_nxt;
  logic       step_last;
  logic       mem_go;
  logic       done_q;
  opcode_e    dec_op;

  ctrl_step_counter #(.STEPS(ALU_STEPS)) u_step (
    .clock  (clock),
    .resetn (resetn),
    .clr    ((state_q != ST_ALU) || step_last),
    .en     (state_q == ST_ALU),
    .count  (step),
    .last   (step_last)
  );

  assign dec_op   = opcode_e'(ir[INSTR_W-1 -: 3]);
  assign step_nxt = step + 3'd1;
  assign mem_go   = MEM_WAIT ? mem_ready : 1'b1;

  // Outputs are registered with the state they belong to, so each branch
  // loads the enables of the state it is entering.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ir        <= '0;
      alu_op    <= ALU_ADD;
      mem_req   <= 1'b0;
      mv_en     <= 1'b0;
      alu_a_en  <= 1'b0;
      alu_g_en  <= 1'b0;
      alu_wb_en <= 1'b0;
      pc_ld_en  <= 1'b0;
      br_en     <= 1'b0;
      done_q    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so these defaults and the
      // overrides below all resolve against the pre-edge state.
      mem_req   <= 1'b0;
      mv_en     <= 1'b0;
      alu_a_en  <= 1'b0;
      alu_g_en  <= 1'b0;
      alu_wb_en <= 1'b0;
      pc_ld_en  <= 1'b0;
      br_en     <= 1'b0;
      done_q    <= 1'b0;
      illegal   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (new_instr) begin
            ir      <= instr;
            state_q <= ST_DECODE;
            illegal <= (opcode_e'(instr[INSTR_W-1 -: 3]) == OP_ILL);
          end
        end
        ST_DECODE: begin
          case (dec_op)
            OP_LD:   begin state_q <= ST_LOAD;   mem_req  <= 1'b1; end
            OP_MV:   begin state_q <= ST_MOV;    mv_en    <= 1'b1; done_q <= 1'b1; end
            OP_LDPC: begin state_q <= ST_LDPC;   pc_ld_en <= 1'b1; done_q <= 1'b1; end
            OP_BR:   begin state_q <= ST_BRANCH; br_en    <= 1'b1; done_q <= 1'b1; end
            OP_ADD, OP_SUB, OP_XOR: begin
              state_q  <= ST_ALU;
              alu_op   <= (dec_op == OP_ADD) ? ALU_ADD :
                          (dec_op == OP_SUB) ? ALU_SUB : ALU_XOR;
              alu_a_en <= 1'b1;
              alu_g_en <= (ALU_STEPS == 2);
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_LOAD: begin
          if (mem_go) begin
            state_q <= ST_IDLE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_ALU: begin
          if (step_last) begin
            state_q <= ST_IDLE;
          end else begin
            alu_g_en  <= (step_nxt == G_STEP);
            alu_wb_en <= (step_nxt == WB_STEP);
            done_q    <= (step_nxt == WB_STEP);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Load completion follows mem_ready within the same cycle.
  assign ld_en    = (state_q == ST_LOAD) && mem_go;
  assign done     = done_q || ld_en;
  assign busy     = (state_q != ST_IDLE);
  assign state    = state_q;
  assign alu_step = step;

endmodule
